// File: rtl/ft_out_arbiter.sv
// Two-requester packet arbiter feeding a registered byte stream into an FT245 output FIFO.
// Optional grant watchdog: define FT_OUT_ARB_TIMEOUT_EN.
module ft_out_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       wr0,
  input  logic       wr1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       last0,
  input  logic       last1,
  output logic       rdy0,
  output logic       rdy1,
  output logic       out_fifo_wr,
  output logic [7:0] out_fifo_data,
  input  logic       out_fifo_full,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       lo_q, lo_d;
  logic       wr_q, wr_d;
  logic [7:0] data_q, data_d;
  logic       acc0, acc1;
  logic       to_fire;

  if (TIMEOUT_CYCLES == 16'd0) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  assign gnt0 = (state_q == OWN0);
  assign gnt1 = (state_q == OWN1);
  assign busy = gnt0 | gnt1;
  assign rdy0 = gnt0 & ~out_fifo_full;
  assign rdy1 = gnt1 & ~out_fifo_full;

  // A non-last byte offered as req drops is part of an abort, not data.
  assign acc0 = wr0 & rdy0 & (req0 | last0);
  assign acc1 = wr1 & rdy1 & (req1 | last1);

  assign out_fifo_wr   = wr_q;
  assign out_fifo_data = data_q;

`ifdef FT_OUT_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = 16'd0;
    end else if (acc0 | acc1) begin
      cnt_d = 16'd0;
    end else if (!out_fifo_full && cnt_q != TIMEOUT_CYCLES) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign to_fire = ((gnt0 & req0) | (gnt1 & req1))
                 & ~(acc0 | acc1)
                 & ~out_fifo_full
                 & (cnt_q == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  assign timeout = to_fire;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    wr_d    = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (req0 && (!req1 || lo_q)) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (acc0) begin
          wr_d   = 1'b1;
          data_d = data0;
        end
        if ((acc0 && last0) || !req0 || to_fire) begin
          state_d = IDLE;
          lo_d    = 1'b0;
        end
      end
      OWN1: begin
        if (acc1) begin
          wr_d   = 1'b1;
          data_d = data1;
        end
        if ((acc1 && last1) || !req1 || to_fire) begin
          state_d = IDLE;
          lo_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lo_q    <= 1'b1;
      wr_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_ft_out_arbiter.sv
// Directed bench for ft_out_arbiter.
// Covers the watchdog too when FT_OUT_ARB_TIMEOUT_EN is defined.
module tb_ft_out_arbiter;

`ifdef FT_OUT_ARB_TIMEOUT_EN
  localparam logic [15:0] TO = 16'd8;
`else
  localparam logic [15:0] TO = 16'd1024;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, gnt0, gnt1;
  logic       wr0, wr1, last0, last1;
  logic [7:0] data0, data1;
  logic       rdy0, rdy1;
  logic       out_fifo_wr;
  logic [7:0] out_fifo_data;
  logic       out_fifo_full;
  logic       busy, timeout;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];

  ft_out_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .gnt0(gnt0), .gnt1(gnt1),
    .wr0(wr0), .wr1(wr1),
    .data0(data0), .data1(data1),
    .last0(last0), .last1(last1),
    .rdy0(rdy0), .rdy1(rdy1),
    .out_fifo_wr(out_fifo_wr),
    .out_fifo_data(out_fifo_data),
    .out_fifo_full(out_fifo_full),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_fifo_wr) log_q.push_back(out_fifo_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got hang exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    last0 = 0; last1 = 0; data0 = 0; data1 = 0;
    out_fifo_full = 0;
  endtask

  initial begin
    int n_aa;
    rst = 1;
    idle_in();
    tick(); tick();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_wr", out_fifo_wr, 0);
    chk("rst_data", out_fifo_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_to", timeout, 0);
    rst = 0;
    tick();

    // single packet
    req0 = 1;
    tick();
    chk("p1_gnt0", gnt0, 1);
    chk("p1_busy", busy, 1);
    chk("p1_rdy0", rdy0, 1);
    wr0 = 1; data0 = 8'hDC;
    tick();
    chk("p1_wr_dc", out_fifo_wr, 1);
    chk("p1_d_dc", out_fifo_data, 8'hDC);
    data0 = 8'h01;
    tick();
    chk("p1_d_01", out_fifo_data, 8'h01);
    data0 = 8'h02; last0 = 1;
    tick();
    chk("p1_d_02", out_fifo_data, 8'h02);
    chk("p1_gnt0_fall", gnt0, 0);
    idle_in();
    tick();
    chk("p1_wr_idle", out_fifo_wr, 0);

    // contention after a fresh reset
    rst = 1; tick(); rst = 0; tick();
    req0 = 1; req1 = 1;
    tick();
    chk("c_gnt0", gnt0, 1);
    chk("c_gnt1", gnt1, 0);
    wr0 = 1; data0 = 8'h11; last0 = 1;
    tick();
    chk("c_d_11", out_fifo_data, 8'h11);
    chk("c_idle_busy", busy, 0);
    req0 = 0; wr0 = 0; last0 = 0;
    tick();
    chk("c_gnt1_up", gnt1, 1);
    wr1 = 1; data1 = 8'h22; last1 = 1;
    tick();
    chk("c_d_22", out_fifo_data, 8'h22);
    req1 = 0; wr1 = 0; last1 = 0;
    tick();
    req0 = 1; req1 = 1;
    tick();
    chk("c2_gnt0", gnt0, 1);

    // backpressure with a stray write from the loser
    wr1 = 1; data1 = 8'hAA;
    wr0 = 1; data0 = 8'h33; out_fifo_full = 1;
    #1;
    chk("bp_rdy0", rdy0, 0);
    chk("bp_rdy1", rdy1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_no_wr", out_fifo_wr, 0);
    end
    out_fifo_full = 0;
    tick();
    chk("bp_wr_33", out_fifo_wr, 1);
    chk("bp_d_33", out_fifo_data, 8'h33);
    wr0 = 0;
    tick();
    chk("bp_no_dup", out_fifo_wr, 0);
    wr0 = 1; data0 = 8'h44; last0 = 1; out_fifo_full = 1;
    tick(); tick();
    chk("fl_hold_gnt0", gnt0, 1);
    chk("fl_no_wr", out_fifo_wr, 0);
    out_fifo_full = 0;
    tick();
    chk("fl_d_44", out_fifo_data, 8'h44);
    chk("fl_gnt0_fall", gnt0, 0);
    req0 = 0; wr0 = 0; last0 = 0; wr1 = 0;

    // abort: req1 still pending wins after owner 0
    tick();
    chk("ab_gnt1", gnt1, 1);
    wr1 = 1; data1 = 8'h51;
    tick();
    data1 = 8'h52;
    tick();
    chk("ab_d_52", out_fifo_data, 8'h52);
    data1 = 8'h53; req1 = 0;
    tick();
    chk("ab_gnt1_fall", gnt1, 0);
    chk("ab_no_wr", out_fifo_wr, 0);
    chk("ab_busy", busy, 0);
    idle_in();
    tick();

    // reset mid-packet
    req0 = 1;
    tick();
    wr0 = 1; data0 = 8'h61;
    rst = 1;
    tick();
    chk("rm_gnt0", gnt0, 0);
    chk("rm_wr", out_fifo_wr, 0);
    chk("rm_data", out_fifo_data, 8'h00);
    chk("rm_busy", busy, 0);
    rst = 0;
    idle_in();
    tick();

    // last byte together with req drop
    req0 = 1;
    tick();
    wr0 = 1; data0 = 8'h71; last0 = 1; req0 = 0;
    tick();
    chk("sl_wr", out_fifo_wr, 1);
    chk("sl_d_71", out_fifo_data, 8'h71);
    chk("sl_gnt0", gnt0, 0);
    idle_in();
    tick();

    // grant hold / watchdog
    req0 = 1;
    tick();
    req1 = 1;
    chk("to_gnt0", gnt0, 1);
`ifdef FT_OUT_ARB_TIMEOUT_EN
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to_quiet", timeout, 0);
    end
    tick();
    chk("to_pulse", timeout, 1);
    chk("to_gnt0_hold", gnt0, 1);
    tick();
    chk("to_gnt0_fall", gnt0, 0);
    chk("to_pulse_end", timeout, 0);
    tick();
    chk("to_gnt1", gnt1, 1);
`else
    for (int i = 0; i < 40; i++) tick();
    chk("nt_timeout", timeout, 0);
    chk("nt_gnt0", gnt0, 1);
    chk("nt_gnt1", gnt1, 0);
`endif
    idle_in();
    tick(); tick();

    exp_q = '{8'hDC, 8'h01, 8'h02, 8'h11, 8'h22,
              8'h33, 8'h44, 8'h51, 8'h52, 8'h71};
    chk("log_len", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("log_%0d", i), log_q[i], exp_q[i]);
    end
    n_aa = 0;
    foreach (log_q[i]) if (log_q[i] == 8'hAA) n_aa++;
    chk("no_aa", n_aa, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
